delivery_pattern_sequencer: RTL and testbench

Sequencer directly upstream/downstream of the delivery pattern ROM (4-bit address in, 4-bit registered data out, 1-cycle read latency). Walks the ROM from a start address for a fixed number of rounds and presents one delivery pattern at a time to the delivery game FSM. It advances only when the game requests the next pattern. The ROM is instantiated beside this block in the delivery game datapath, not inside it.

---
 rtl/delivery_pattern_sequencer_pkg.sv | 22 ++
 rtl/delivery_pattern_sequencer_if.sv | 28 ++
 rtl/delivery_pattern_sequencer.sv | 98 +++++++++
 tb/tb_delivery_pattern_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_pattern_sequencer_pkg.sv
// Delivery game shared types and widths.
// Used by the sequencer, the game FSM and the ROM wrapper.
package delivery_pattern_sequencer_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int PATTERN_W  = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE,
    PRESENT = ST_PRESENT,
    FINISH  = ST_FINISH
  } state_t;

endpackage

// File: rtl/delivery_pattern_sequencer_if.sv
// Sequencer <-> game / pattern ROM signal bundle.
// master is the sequencer side, slave the game/ROM side.
interface delivery_pattern_sequencer_if;
  import delivery_pattern_sequencer_pkg::*;

  logic                  start;
  logic                  next;
  logic [ROM_ADDR_W-1:0] rom_address;
  logic [PATTERN_W-1:0]  rom_data;
  logic [PATTERN_W-1:0]  pattern;
  logic                  pattern_valid;
  logic [ROM_ADDR_W-1:0] index;
  logic                  last;
  logic                  done;

  modport master (
    input  start, next, rom_data,
    output rom_address, pattern, pattern_valid,
    output index, last, done
  );

  modport slave (
    output start, next, rom_data,
    input  rom_address, pattern, pattern_valid,
    input  index, last, done
  );

endinterface

// File: rtl/delivery_pattern_sequencer.sv
// Walks the pattern ROM one entry per game round.
// Each step: ISSUE address, CAPTURE data, PRESENT until next.
module delivery_pattern_sequencer
  import delivery_pattern_sequencer_pkg::*;
#(
  parameter int SEQ_LEN    = 16,
  parameter int START_ADDR = 0
) (
  input logic clock,
  input logic reset,
  delivery_pattern_sequencer_if.master bus
);

  localparam logic [ROM_ADDR_W-1:0] LAST_IDX =
    ROM_ADDR_W'(SEQ_LEN - 1);
  localparam logic [ROM_ADDR_W-1:0] FIRST =
    ROM_ADDR_W'(START_ADDR);
  localparam logic [ROM_ADDR_W-1:0] ONE =
    ROM_ADDR_W'(1);

  state_t                state;
  state_t                state_nx;
  logic [ROM_ADDR_W-1:0] addr_q;
  logic [ROM_ADDR_W-1:0] idx_q;
  logic [PATTERN_W-1:0]  pat_q;
  logic                  vld_q;
  logic                  done_q;
  logic                  at_end;

  assign at_end = (idx_q == LAST_IDX);

  assign bus.rom_address   = addr_q;
  assign bus.pattern       = pat_q;
  assign bus.pattern_valid = vld_q;
  assign bus.index         = idx_q;
  assign bus.done          = done_q;
  assign bus.last          = vld_q && at_end;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = PRESENT;
      PRESENT: begin
        if (bus.next)
          state_nx = at_end ? FINISH : ISSUE;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address, round index, pattern and done registers
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      idx_q  <= '0;
      pat_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            addr_q <= FIRST;
            idx_q  <= '0;
          end
        end
        CAPTURE: begin
          pat_q <= bus.rom_data;
          vld_q <= 1'b1;
        end
        PRESENT: begin
          if (bus.next) begin
            vld_q <= 1'b0;
            if (at_end) begin
              done_q <= 1'b1;
            end else begin
              idx_q  <= idx_q + ONE;
              addr_q <= addr_q + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delivery_pattern_sequencer.sv
// Bench for delivery_pattern_sequencer with a ROM model.
// Three instances cover default, wrap-around and single-round runs.
module tb_delivery_pattern_sequencer;

  localparam logic [3:0] ROM_IMG [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b1001, 4'b1010, 4'b1100, 4'b0110,
    4'b0101, 4'b0011, 4'b1110, 4'b1101,
    4'b1011, 4'b0111, 4'b1000, 4'b0110
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  delivery_pattern_sequencer_if ba();
  delivery_pattern_sequencer_if bw();
  delivery_pattern_sequencer_if b1();

  delivery_pattern_sequencer #(
    .SEQ_LEN(16), .START_ADDR(0)
  ) dut_a (.clock(clock), .reset(reset), .bus(ba.master));

  delivery_pattern_sequencer #(
    .SEQ_LEN(4), .START_ADDR(14)
  ) dut_w (.clock(clock), .reset(reset), .bus(bw.master));

  delivery_pattern_sequencer #(
    .SEQ_LEN(1), .START_ADDR(0)
  ) dut_1 (.clock(clock), .reset(reset), .bus(b1.master));

  // Registered pattern ROMs: one-cycle read latency
  always @(posedge clock) begin
    ba.rom_data <= ROM_IMG[ba.rom_address];
    bw.rom_data <= ROM_IMG[bw.rom_address];
    b1.rom_data <= ROM_IMG[b1.rom_address];
  end

  // Reference: round k shows ROM entry (base + k) mod 16
  function automatic logic [3:0] exp_pat(int base, int k);
    return ROM_IMG[(base + k) % 16];
  endfunction

  function automatic logic [3:0] exp_addr(int base, int k);
    return 4'((base + k) % 16);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ba_step();
    ba.next = 1'b1;
    tick();
    ba.next = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ba.pattern, ba.pattern_valid, ba.index,
         ba.done, ba.last, ba.rom_address} !== 15'd0) begin
      errors++;
      $display("FAIL reset_a got p=%b v=%b i=%0d d=%b l=%b a=%0d exp all 0",
        ba.pattern, ba.pattern_valid, ba.index,
        ba.done, ba.last, ba.rom_address);
    end
    checks++;
    if ({bw.pattern_valid, bw.rom_address, bw.done,
         b1.pattern_valid, b1.last, b1.done} !== 9'd0) begin
      errors++;
      $display("FAIL reset_wb got w.v=%b w.a=%0d w.d=%b 1.v=%b 1.l=%b 1.d=%b exp 0",
        bw.pattern_valid, bw.rom_address, bw.done,
        b1.pattern_valid, b1.last, b1.done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_pattern();
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    checks++;
    if (ba.pattern_valid !== 1'b0 || ba.rom_address !== 4'd0) begin
      errors++;
      $display("FAIL lat_edge1 got v=%b a=%0d exp v=0 a=0",
        ba.pattern_valid, ba.rom_address);
    end
    tick();
    checks++;
    if (ba.pattern_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge2 got v=%b exp 0", ba.pattern_valid);
    end
    tick();
    checks++;
    if ({ba.pattern_valid, ba.pattern, ba.index, ba.last}
        !== {1'b1, exp_pat(0, 0), 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL first got v=%b p=%b i=%0d l=%b exp v=1 p=%b i=0 l=0",
        ba.pattern_valid, ba.pattern, ba.index, ba.last, exp_pat(0, 0));
    end
    ba_step();
    checks++;
    if ({ba.pattern_valid, ba.pattern, ba.index}
        !== {1'b1, exp_pat(0, 1), 4'd1}) begin
      errors++;
      $display("FAIL second got v=%b p=%b i=%0d exp v=1 p=%b i=1",
        ba.pattern_valid, ba.pattern, ba.index, exp_pat(0, 1));
    end
  endtask

  task automatic test_full_run();
    for (int k = 1; k < 16; k++) begin
      int w;
      w = $urandom_range(0, 3);
      for (int j = 0; j < w; j++) begin
        ba.start = 1'($urandom_range(0, 1));
        tick();
      end
      ba.start = 1'b0;
      checks++;
      if ({ba.pattern_valid, ba.pattern, ba.index, ba.last}
          !== {1'b1, exp_pat(0, k), 4'(k), 1'(k == 15)}) begin
        errors++;
        $display("FAIL run_k%0d got v=%b p=%b i=%0d l=%b exp p=%b l=%b",
          k, ba.pattern_valid, ba.pattern, ba.index, ba.last,
          exp_pat(0, k), k == 15);
      end
      ba.next = 1'b1;
      tick();
      ba.next = 1'b0;
      if (k < 15) begin
        checks++;
        if ({ba.pattern_valid, ba.last, ba.done} !== 3'b000) begin
          errors++;
          $display("FAIL adv_k%0d got v=%b l=%b d=%b exp 000",
            k, ba.pattern_valid, ba.last, ba.done);
        end
        ba.next = 1'($urandom_range(0, 1));
        tick();
        ba.next = 1'($urandom_range(0, 1));
        tick();
        ba.next = 1'b0;
      end
    end
    checks++;
    if ({ba.done, ba.pattern_valid, ba.last} !== 3'b100) begin
      errors++;
      $display("FAIL done_rise got d=%b v=%b l=%b exp 100",
        ba.done, ba.pattern_valid, ba.last);
    end
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    checks++;
    if (ba.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got d=%b exp 0", ba.done);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({ba.pattern_valid, ba.rom_address, ba.index, ba.pattern}
        !== {1'b0, 4'd15, 4'd15, exp_pat(0, 15)}) begin
      errors++;
      $display("FAIL finish_start got v=%b a=%0d i=%0d p=%b exp v=0 a=15 i=15 p=%b",
        ba.pattern_valid, ba.rom_address, ba.index, ba.pattern,
        exp_pat(0, 15));
    end
  endtask

  task automatic test_ignored();
    ba.next = 1'b1;
    tick();
    tick();
    tick();
    ba.next = 1'b0;
    checks++;
    if ({ba.pattern_valid, ba.index, ba.rom_address}
        !== {1'b0, 4'd15, 4'd15}) begin
      errors++;
      $display("FAIL idle_next got v=%b i=%0d a=%0d exp v=0 i=15 a=15",
        ba.pattern_valid, ba.index, ba.rom_address);
    end
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    tick();
    tick();
    ba_step();
    ba_step();
    checks++;
    if ({ba.pattern_valid, ba.pattern, ba.index}
        !== {1'b1, exp_pat(0, 2), 4'd2}) begin
      errors++;
      $display("FAIL restart_i2 got v=%b p=%b i=%0d exp p=%b i=2",
        ba.pattern_valid, ba.pattern, ba.index, exp_pat(0, 2));
    end
    ba.start = 1'b1;
    ba.next  = 1'b1;
    tick();
    ba.start = 1'b0;
    ba.next  = 1'b0;
    checks++;
    if ({ba.pattern_valid, ba.index, ba.rom_address}
        !== {1'b0, 4'd3, exp_addr(0, 3)}) begin
      errors++;
      $display("FAIL both_adv got v=%b i=%0d a=%0d exp v=0 i=3 a=3",
        ba.pattern_valid, ba.index, ba.rom_address);
    end
    tick();
    tick();
    tick();
    tick();
    tick();
    checks++;
    if ({ba.pattern_valid, ba.pattern, ba.index}
        !== {1'b1, exp_pat(0, 3), 4'd3}) begin
      errors++;
      $display("FAIL both_hold got v=%b p=%b i=%0d exp p=%b i=3",
        ba.pattern_valid, ba.pattern, ba.index, exp_pat(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    ba_step();
    ba.next = 1'b1;
    tick();
    ba.next = 1'b0;
    tick();
    checks++;
    if ({ba.pattern_valid, ba.index} !== {1'b0, 4'd5}) begin
      errors++;
      $display("FAIL pre_reset got v=%b i=%0d exp v=0 i=5",
        ba.pattern_valid, ba.index);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ba.pattern, ba.pattern_valid, ba.index,
         ba.done, ba.rom_address} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset got p=%b v=%b i=%0d d=%b a=%0d exp all 0",
        ba.pattern, ba.pattern_valid, ba.index,
        ba.done, ba.rom_address);
    end
    tick();
    tick();
    checks++;
    if (ba.pattern_valid !== 1'b0) begin
      errors++;
      $display("FAIL inflight got v=%b exp 0", ba.pattern_valid);
    end
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    tick();
    tick();
    checks++;
    if ({ba.pattern_valid, ba.pattern, ba.index}
        !== {1'b1, exp_pat(0, 0), 4'd0}) begin
      errors++;
      $display("FAIL post_reset got v=%b p=%b i=%0d exp v=1 p=%b i=0",
        ba.pattern_valid, ba.pattern, ba.index, exp_pat(0, 0));
    end
  endtask

  task automatic test_wrap();
    bw.start = 1'b1;
    tick();
    bw.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int w;
      checks++;
      if ({bw.pattern_valid, bw.rom_address}
          !== {1'b0, exp_addr(14, k)}) begin
        errors++;
        $display("FAIL wrap_addr%0d got v=%b a=%0d exp v=0 a=%0d",
          k, bw.pattern_valid, bw.rom_address, exp_addr(14, k));
      end
      tick();
      tick();
      checks++;
      if ({bw.pattern_valid, bw.pattern, bw.index, bw.last}
          !== {1'b1, exp_pat(14, k), 4'(k), 1'(k == 3)}) begin
        errors++;
        $display("FAIL wrap_pat%0d got v=%b p=%b i=%0d l=%b exp p=%b",
          k, bw.pattern_valid, bw.pattern, bw.index, bw.last,
          exp_pat(14, k));
      end
      w = $urandom_range(0, 2);
      for (int j = 0; j < w; j++) tick();
      bw.next = 1'b1;
      tick();
      bw.next = 1'b0;
    end
    checks++;
    if ({bw.done, bw.pattern_valid} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_done got d=%b v=%b exp d=1 v=0",
        bw.done, bw.pattern_valid);
    end
    tick();
    checks++;
    if (bw.done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done_w got d=%b exp 0", bw.done);
    end
  endtask

  task automatic test_seq_len_one();
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    tick();
    tick();
    checks++;
    if ({b1.pattern_valid, b1.pattern, b1.index, b1.last}
        !== {1'b1, exp_pat(0, 0), 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL one_pat got v=%b p=%b i=%0d l=%b exp v=1 p=%b i=0 l=1",
        b1.pattern_valid, b1.pattern, b1.index, b1.last, exp_pat(0, 0));
    end
    b1.next = 1'b1;
    tick();
    b1.next = 1'b0;
    checks++;
    if ({b1.done, b1.pattern_valid, b1.last} !== 3'b100) begin
      errors++;
      $display("FAIL one_done got d=%b v=%b l=%b exp 100",
        b1.done, b1.pattern_valid, b1.last);
    end
    tick();
    checks++;
    if (b1.done !== 1'b0) begin
      errors++;
      $display("FAIL one_done_w got d=%b exp 0", b1.done);
    end
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    tick();
    tick();
    checks++;
    if ({b1.pattern_valid, b1.pattern, b1.index}
        !== {1'b1, exp_pat(0, 0), 4'd0}) begin
      errors++;
      $display("FAIL one_restart got v=%b p=%b i=%0d exp v=1 p=%b i=0",
        b1.pattern_valid, b1.pattern, b1.index, exp_pat(0, 0));
    end
  endtask

  initial begin
    ba.start = 1'b0;
    ba.next  = 1'b0;
    bw.start = 1'b0;
    bw.next  = 1'b0;
    b1.start = 1'b0;
    b1.next  = 1'b0;
    test_reset();
    test_first_pattern();
    test_full_run();
    test_ignored();
    test_reset_mid();
    test_wrap();
    test_seq_len_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
